pc_ctrl: RTL and testbench

Parametrised program-counter unit for the single-cycle/multi-cycle MIPS core, successor to the plain PC register. It holds the fetch address, advances it by a configurable step on a fetch handshake, and selects among branch, jump, ERET and exception redirects by fixed priority. Redirects that arrive during a stall are buffered, and misaligned targets are trapped. It sits between the next-PC logic in decode/execute and the instruction-memory port.

---
 rtl/pc_ctrl_pkg.sv | 33 +++
 rtl/pc_ctrl_if.sv | 38 +++
 rtl/pc_redirect_arb.sv | 70 +++++++
 rtl/pc_ctrl.sv | 149 ++++++++++++++
 tb/tb_pc_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pc_ctrl_pkg -- shared definitions for the program-counter unit.
//   redirect_kind_e : redirect source encoding; numeric order equals priority,
//                     so priority comparisons are plain magnitude compares.
//   state_e         : controller FSM states.
//   DEF_*_VECTOR    : default reset and exception-handler addresses.
//   kind_has_target : true for redirects whose target comes from the
//                     pipeline and therefore needs an alignment check.
// ---------------------------------------------------------------------------
package pc_ctrl_pkg;

  typedef enum logic [2:0] {
    KIND_NONE = 3'd0,
    KIND_BR   = 3'd1,
    KIND_JMP  = 3'd2,
    KIND_ERET = 3'd3,
    KIND_EXC  = 3'd4
  } redirect_kind_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_4180;

  // The exception vector is a constant and is never checked for alignment.
  function automatic logic kind_has_target(input redirect_kind_e kind);
    return (kind == KIND_BR) || (kind == KIND_JMP) || (kind == KIND_ERET);
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_ctrl_if -- bundle between the next-PC logic / instruction-memory port
// (master) and the program-counter unit (slave).
//   master drives : fetch_ready, stall, br_taken/br_target, jump/jump_target,
//                   eret/epc_in, exc_req
//   slave drives  : pc, pc_valid, epc, addr_err
// ---------------------------------------------------------------------------
interface pc_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             fetch_ready;
  logic             stall;
  logic             br_taken;
  logic [WIDTH-1:0] br_target;
  logic             jump;
  logic [WIDTH-1:0] jump_target;
  logic             eret;
  logic [WIDTH-1:0] epc_in;
  logic             exc_req;
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic [WIDTH-1:0] epc;
  logic             addr_err;

  modport master (
    output fetch_ready, stall, br_taken, br_target, jump, jump_target,
           eret, epc_in, exc_req,
    input  pc, pc_valid, epc, addr_err
  );

  modport slave (
    input  fetch_ready, stall, br_taken, br_target, jump, jump_target,
           eret, epc_in, exc_req,
    output pc, pc_valid, epc, addr_err
  );

endinterface

// File: rtl/pc_redirect_arb.sv
// ---------------------------------------------------------------------------
// pc_redirect_arb -- combinational redirect selection.
// Picks the highest-priority incoming redirect (exc > eret > jump > branch),
// then resolves it against the pending slot: the incoming one wins when its
// priority is at least the pending one's. The winner is checked for
// alignment against STEP.
//   exc_req_i/eret_i/jump_i/br_taken_i : incoming redirect requests
//   epc_in_i/jump_target_i/br_target_i : their targets
//   pend_kind_i/pend_target_i          : buffered redirect (KIND_NONE = empty)
//   kind_o/target_o                    : selected redirect (KIND_NONE = none)
//   misaligned_o                       : selected target violates alignment
// ---------------------------------------------------------------------------
module pc_redirect_arb
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR),
  parameter int               STEP       = 4
) (
  input  logic             exc_req_i,
  input  logic             eret_i,
  input  logic             jump_i,
  input  logic             br_taken_i,
  input  logic [WIDTH-1:0] epc_in_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic [WIDTH-1:0] br_target_i,
  input  redirect_kind_e   pend_kind_i,
  input  logic [WIDTH-1:0] pend_target_i,
  output redirect_kind_e   kind_o,
  output logic [WIDTH-1:0] target_o,
  output logic             misaligned_o
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

  redirect_kind_e   in_kind;
  logic [WIDTH-1:0] in_target;

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    in_kind   = KIND_NONE;
    in_target = '0;
    if (exc_req_i) begin
      in_kind   = KIND_EXC;
      in_target = EXC_VECTOR;
    end else if (eret_i) begin
      in_kind   = KIND_ERET;
      in_target = epc_in_i;
    end else if (jump_i) begin
      in_kind   = KIND_JMP;
      in_target = jump_target_i;
    end else if (br_taken_i) begin
      in_kind   = KIND_BR;
      in_target = br_target_i;
    end
  end

  always_comb begin
    kind_o   = pend_kind_i;
    target_o = pend_target_i;
    if ((in_kind != KIND_NONE) && (in_kind >= pend_kind_i)) begin
      kind_o   = in_kind;
      target_o = in_target;
    end
  end

  assign misaligned_o = kind_has_target(kind_o) && ((target_o & ALIGN_MASK) != '0);

endmodule

// File: rtl/pc_ctrl.sv
// ---------------------------------------------------------------------------
// pc_ctrl -- program-counter unit.
// Holds the fetch address, advances it by STEP on each accepted fetch and
// applies branch/jump/ERET/exception redirects by fixed priority. Redirects
// seen while stalled are buffered in a one-entry pending slot and applied
// when the stall drops. Misaligned targets are trapped to EXC_VECTOR at
// load time, capturing the offending target in epc and pulsing addr_err.
//   clk_i   : clock, all state changes on rising edge
//   reset_i : synchronous, active-low reset
//   bus     : pc_ctrl_if slave (requests in; pc/pc_valid/epc/addr_err out,
//             all registered)
// ---------------------------------------------------------------------------
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int               STEP         = 4
) (
  input  logic     clk_i,
  input  logic     reset_i,
  pc_ctrl_if.slave bus
);

  state_e           state_q,       state_d;
  logic [WIDTH-1:0] pc_q,          pc_d;
  logic             pc_valid_q,    pc_valid_d;
  logic [WIDTH-1:0] epc_q,         epc_d;
  logic             addr_err_q,    addr_err_d;
  redirect_kind_e   pend_kind_q,   pend_kind_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;

  redirect_kind_e   sel_kind;
  logic [WIDTH-1:0] sel_target;
  logic             sel_misaligned;
  logic             fire;
  logic             load;

  // The pending slot only ever holds a redirect in ST_PEND, so feeding it
  // unconditionally lets one arbiter serve both states.
  pc_redirect_arb #(
    .WIDTH      (WIDTH),
    .EXC_VECTOR (EXC_VECTOR),
    .STEP       (STEP)
  ) u_arb (
    .exc_req_i     (bus.exc_req),
    .eret_i        (bus.eret),
    .jump_i        (bus.jump),
    .br_taken_i    (bus.br_taken),
    .epc_in_i      (bus.epc_in),
    .jump_target_i (bus.jump_target),
    .br_target_i   (bus.br_target),
    .pend_kind_i   (pend_kind_q),
    .pend_target_i (pend_target_q),
    .kind_o        (sel_kind),
    .target_o      (sel_target),
    .misaligned_o  (sel_misaligned)
  );

  assign fire = pc_valid_q & bus.fetch_ready & ~bus.stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    epc_d         = epc_q;
    addr_err_d    = 1'b0;
    pend_kind_d   = pend_kind_q;
    pend_target_d = pend_target_q;
    load          = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (sel_kind != KIND_NONE) begin
          if (!bus.stall) begin
            // A redirect is taken even without fetch_ready: the wrong-path
            // pc is simply dropped.
            load = 1'b1;
          end else begin
            pend_kind_d   = sel_kind;
            pend_target_d = sel_target;
            state_d       = ST_PEND;
          end
        end else if (fire) begin
          pc_d = pc_q + WIDTH'(STEP);
        end
      end
      ST_PEND: begin
        if (!bus.stall) begin
          load          = 1'b1;
          pend_kind_d   = KIND_NONE;
          pend_target_d = '0;
          state_d       = ST_RUN;
        end else begin
          // The arbiter already kept the pending entry unless an incoming
          // redirect of equal or higher priority displaced it.
          pend_kind_d   = sel_kind;
          pend_target_d = sel_target;
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Alignment is judged here, when the target is actually loaded, so a
    // buffered target is checked against the same rule as a direct one.
    if (load) begin
      if (sel_misaligned) begin
        pc_d       = EXC_VECTOR;
        epc_d      = sel_target;
        addr_err_d = 1'b1;
      end else begin
        pc_d = sel_target;
        if (sel_kind == KIND_EXC) begin
          epc_d = pc_q;
        end
      end
    end
  end

  assign pc_valid_d = (state_d == ST_RUN);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= ST_RUN;
      pc_q          <= RESET_VECTOR;
      pc_valid_q    <= 1'b0;
      epc_q         <= '0;
      addr_err_q    <= 1'b0;
      pend_kind_q   <= KIND_NONE;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_valid_q    <= pc_valid_d;
      epc_q         <= epc_d;
      addr_err_q    <= addr_err_d;
      pend_kind_q   <= pend_kind_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.epc      = epc_q;
  assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_ctrl -- directed bench for pc_ctrl: a 32-bit instance covers reset,
// sequencing, priority, stall buffering, alignment traps and exceptions; a
// 16-bit instance covers address wrap-around.
// ---------------------------------------------------------------------------
module tb_pc_ctrl;

  logic clk = 1'b0;
  logic reset32;
  logic reset16;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  pc_ctrl_if #(.WIDTH(32)) bus32 ();
  pc_ctrl_if #(.WIDTH(16)) bus16 ();

  pc_ctrl #(.WIDTH(32)) dut32 (
    .clk_i   (clk),
    .reset_i (reset32),
    .bus     (bus32.slave)
  );

  pc_ctrl #(.WIDTH(16)) dut16 (
    .clk_i   (clk),
    .reset_i (reset16),
    .bus     (bus16.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    bus32.stall       = 1'b0;
    bus32.br_taken    = 1'b0;
    bus32.br_target   = '0;
    bus32.jump        = 1'b0;
    bus32.jump_target = '0;
    bus32.eret        = 1'b0;
    bus32.epc_in      = '0;
    bus32.exc_req     = 1'b0;
  endtask

  task automatic idle16();
    bus16.stall       = 1'b0;
    bus16.br_taken    = 1'b0;
    bus16.br_target   = '0;
    bus16.jump        = 1'b0;
    bus16.jump_target = '0;
    bus16.eret        = 1'b0;
    bus16.epc_in      = '0;
    bus16.exc_req     = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    reset32 = 1'b0;
    idle32();
    bus32.fetch_ready = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({bus32.pc, bus32.pc_valid, bus32.epc, bus32.addr_err} !== {32'h3000, 1'b0, 32'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_state: got pc=%h v=%b epc=%h ae=%b, expected pc=00003000 v=0 epc=00000000 ae=0",
               bus32.pc, bus32.pc_valid, bus32.epc, bus32.addr_err);
    end
    reset32 = 1'b1;
    step();
    n_checks++;
    if ({bus32.pc, bus32.pc_valid} !== {32'h3000, 1'b1}) begin
      n_errors++;
      $display("FAIL reset_release: got pc=%h v=%b, expected pc=00003000 v=1", bus32.pc, bus32.pc_valid);
    end
    for (int i = 1; i <= 2; i++) begin
      step();
      exp_pc = 32'h3000 + 32'(4 * i);
      n_checks++;
      if ({bus32.pc, bus32.pc_valid} !== {exp_pc, 1'b1}) begin
        n_errors++;
        $display("FAIL seq_%0d: got pc=%h v=%b, expected pc=%h v=1", i, bus32.pc, bus32.pc_valid, exp_pc);
      end
    end
  endtask

  task automatic test_priority();
    bus32.br_taken    = 1'b1;
    bus32.br_target   = 32'h3040;
    bus32.jump        = 1'b1;
    bus32.jump_target = 32'h3100;
    step();
    idle32();
    n_checks++;
    if ({bus32.pc, bus32.pc_valid, bus32.addr_err} !== {32'h3100, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL jump_over_branch: got pc=%h v=%b ae=%b, expected pc=00003100 v=1 ae=0",
               bus32.pc, bus32.pc_valid, bus32.addr_err);
    end
  endtask

  task automatic test_stall_pending();
    bus32.stall = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      bus32.br_taken = (c == 1) || (c == 3);
      bus32.br_target = (c == 1) ? 32'h3200 : 32'h3400;
      bus32.jump = (c == 2);
      bus32.jump_target = 32'h3300;
      step();
      n_checks++;
      if ({bus32.pc, bus32.pc_valid} !== {32'h3100, 1'b0}) begin
        n_errors++;
        $display("FAIL stall_hold_%0d: got pc=%h v=%b, expected pc=00003100 v=0", c, bus32.pc, bus32.pc_valid);
      end
    end
    idle32();
    step();
    n_checks++;
    if ({bus32.pc, bus32.pc_valid} !== {32'h3300, 1'b1}) begin
      n_errors++;
      $display("FAIL pending_load: got pc=%h v=%b, expected pc=00003300 v=1", bus32.pc, bus32.pc_valid);
    end
    step();
    n_checks++;
    if (bus32.pc !== 32'h3304) begin
      n_errors++;
      $display("FAIL after_pending_seq: got pc=%h, expected pc=00003304", bus32.pc);
    end
  endtask

  task automatic test_misaligned();
    bus32.jump        = 1'b1;
    bus32.jump_target = 32'h3102;
    step();
    idle32();
    n_checks++;
    if ({bus32.pc, bus32.epc, bus32.addr_err, bus32.pc_valid} !== {32'h4180, 32'h3102, 1'b1, 1'b1}) begin
      n_errors++;
      $display("FAIL misaligned_jump: got pc=%h epc=%h ae=%b v=%b, expected pc=00004180 epc=00003102 ae=1 v=1",
               bus32.pc, bus32.epc, bus32.addr_err, bus32.pc_valid);
    end
    step();
    n_checks++;
    if ({bus32.pc, bus32.addr_err} !== {32'h4184, 1'b0}) begin
      n_errors++;
      $display("FAIL addr_err_pulse: got pc=%h ae=%b, expected pc=00004184 ae=0", bus32.pc, bus32.addr_err);
    end
  endtask

  task automatic test_exception();
    bus32.jump        = 1'b1;
    bus32.jump_target = 32'h3010;
    step();
    idle32();
    n_checks++;
    if (bus32.pc !== 32'h3010) begin
      n_errors++;
      $display("FAIL jump_3010: got pc=%h, expected pc=00003010", bus32.pc);
    end
    bus32.exc_req = 1'b1;
    bus32.eret    = 1'b1;
    bus32.epc_in  = 32'h3014;
    step();
    idle32();
    n_checks++;
    if ({bus32.pc, bus32.epc, bus32.addr_err} !== {32'h4180, 32'h3010, 1'b0}) begin
      n_errors++;
      $display("FAIL exc_over_eret: got pc=%h epc=%h ae=%b, expected pc=00004180 epc=00003010 ae=0",
               bus32.pc, bus32.epc, bus32.addr_err);
    end
    step();
    bus32.eret   = 1'b1;
    bus32.epc_in = 32'h3014;
    step();
    idle32();
    n_checks++;
    if ({bus32.pc, bus32.epc, bus32.pc_valid} !== {32'h3014, 32'h3010, 1'b1}) begin
      n_errors++;
      $display("FAIL eret_return: got pc=%h epc=%h v=%b, expected pc=00003014 epc=00003010 v=1",
               bus32.pc, bus32.epc, bus32.pc_valid);
    end
  endtask

  task automatic test_exc_during_stall();
    bus32.stall   = 1'b1;
    bus32.exc_req = 1'b1;
    step();
    bus32.exc_req     = 1'b0;
    bus32.jump        = 1'b1;
    bus32.jump_target = 32'h3500;
    step();
    n_checks++;
    if ({bus32.pc, bus32.pc_valid} !== {32'h3014, 1'b0}) begin
      n_errors++;
      $display("FAIL exc_buffered: got pc=%h v=%b, expected pc=00003014 v=0", bus32.pc, bus32.pc_valid);
    end
    idle32();
    bus32.br_taken  = 1'b1;
    bus32.br_target = 32'h3600;
    step();
    idle32();
    n_checks++;
    if ({bus32.pc, bus32.epc, bus32.pc_valid} !== {32'h4180, 32'h3014, 1'b1}) begin
      n_errors++;
      $display("FAIL exc_from_pending: got pc=%h epc=%h v=%b, expected pc=00004180 epc=00003014 v=1",
               bus32.pc, bus32.epc, bus32.pc_valid);
    end
  endtask

  task automatic test_misaligned_pending();
    bus32.stall     = 1'b1;
    bus32.br_taken  = 1'b1;
    bus32.br_target = 32'h3201;
    step();
    idle32();
    n_checks++;
    if ({bus32.addr_err, bus32.pc_valid, bus32.epc} !== {1'b0, 1'b0, 32'h3014}) begin
      n_errors++;
      $display("FAIL no_trap_at_latch: got ae=%b v=%b epc=%h, expected ae=0 v=0 epc=00003014",
               bus32.addr_err, bus32.pc_valid, bus32.epc);
    end
    step();
    n_checks++;
    if ({bus32.pc, bus32.epc, bus32.addr_err} !== {32'h4180, 32'h3201, 1'b1}) begin
      n_errors++;
      $display("FAIL trap_at_load: got pc=%h epc=%h ae=%b, expected pc=00004180 epc=00003201 ae=1",
               bus32.pc, bus32.epc, bus32.addr_err);
    end
  endtask

  task automatic test_reset_mid_pend();
    bus32.stall       = 1'b1;
    bus32.jump        = 1'b1;
    bus32.jump_target = 32'h3600;
    step();
    idle32();
    bus32.stall = 1'b1;
    reset32     = 1'b0;
    step();
    n_checks++;
    if ({bus32.pc, bus32.pc_valid, bus32.epc, bus32.addr_err} !== {32'h3000, 1'b0, 32'h0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_mid_pend: got pc=%h v=%b epc=%h ae=%b, expected pc=00003000 v=0 epc=00000000 ae=0",
               bus32.pc, bus32.pc_valid, bus32.epc, bus32.addr_err);
    end
    reset32     = 1'b1;
    bus32.stall = 1'b0;
    step();
    n_checks++;
    if ({bus32.pc, bus32.pc_valid} !== {32'h3000, 1'b1}) begin
      n_errors++;
      $display("FAIL pending_discarded: got pc=%h v=%b, expected pc=00003000 v=1", bus32.pc, bus32.pc_valid);
    end
  endtask

  task automatic test_wrap();
    idle16();
    bus16.fetch_ready = 1'b1;
    step();
    n_checks++;
    if ({bus16.pc, bus16.pc_valid} !== {16'h3000, 1'b0}) begin
      n_errors++;
      $display("FAIL w16_reset: got pc=%h v=%b, expected pc=3000 v=0", bus16.pc, bus16.pc_valid);
    end
    reset16 = 1'b1;
    step();
    bus16.jump        = 1'b1;
    bus16.jump_target = 16'hFFFC;
    step();
    idle16();
    n_checks++;
    if ({bus16.pc, bus16.pc_valid} !== {16'hFFFC, 1'b1}) begin
      n_errors++;
      $display("FAIL w16_jump: got pc=%h v=%b, expected pc=fffc v=1", bus16.pc, bus16.pc_valid);
    end
    step();
    n_checks++;
    if ({bus16.pc, bus16.pc_valid, bus16.addr_err} !== {16'h0000, 1'b1, 1'b0}) begin
      n_errors++;
      $display("FAIL w16_wrap: got pc=%h v=%b ae=%b, expected pc=0000 v=1 ae=0",
               bus16.pc, bus16.pc_valid, bus16.addr_err);
    end
  endtask

  initial begin
    reset32 = 1'b0;
    reset16 = 1'b0;
    bus32.fetch_ready = 1'b0;
    bus16.fetch_ready = 1'b0;
    idle32();
    idle16();
    test_reset();
    test_priority();
    test_stall_pending();
    test_misaligned();
    test_exception();
    test_exc_during_stall();
    test_misaligned_pending();
    test_reset_mid_pend();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
